// File: rtl/jump_ctrl.sv
// Next-PC sequencer: owns the program counter, inserts a one-cycle jump-table
// lookup on taken branches, and sequences start/stall/halt for the core.
module jump_ctrl #(
  parameter int PC_W     = 10,
  parameter bit ABS_JUMP = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_en,
  input  logic            branch_cond,
  input  logic            halt_req,
  input  logic [7:0]      jptr_in,
  output logic [7:0]      jlut_ptr,
  input  logic [7:0]      jlut_val,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            jump_taken,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, RUN, JUMP, DONE} state_t;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [7:0]      jlut_ptr_reg, jlut_ptr_next;
  logic            jump_taken_reg, jump_taken_next;
  logic [PC_W-1:0] jump_target;

  // Table value is either an absolute target or a signed offset from the branch PC.
  generate
    if (ABS_JUMP) begin : g_abs
      assign jump_target = PC_W'(jlut_val);
    end else begin : g_rel
      assign jump_target = pc_reg + PC_W'($signed(jlut_val));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pc_reg         <= '0;
      jlut_ptr_reg   <= '0;
      jump_taken_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      jlut_ptr_reg   <= jlut_ptr_next;
      jump_taken_reg <= jump_taken_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    jlut_ptr_next   = jlut_ptr_reg;
    jump_taken_next = 1'b0;
    unique case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          pc_next    = '0;
        end
      end
      RUN: begin
        // Stall freezes everything, including a pending halt or branch.
        if (!stall) begin
          if (halt_req) begin
            state_next = DONE;
          end else if (branch_en && branch_cond) begin
            jlut_ptr_next = jptr_in;
            state_next    = JUMP;
          end else begin
            pc_next = pc_reg + PC_W'(1);
          end
        end
      end
      JUMP: begin
        state_next      = RUN;
        pc_next         = jump_target;
        jump_taken_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_valid = (state_reg == RUN);
    done     = (state_reg == DONE);
  end

  assign pc         = pc_reg;
  assign jlut_ptr   = jlut_ptr_reg;
  assign jump_taken = jump_taken_reg;

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl (PC_W=10, relative jumps) with a modelled jump LUT.
module tb_jump_ctrl;

  localparam int PC_W = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0, stall = 1'b0, branch_en = 1'b0, branch_cond = 1'b0, halt_req = 1'b0;
  logic [7:0]      jptr_in = '0;
  logic [7:0]      jlut_ptr;
  logic [7:0]      jlut_val;
  logic [PC_W-1:0] pc;
  logic            pc_valid, jump_taken, done;

  logic [7:0] lut [256];
  assign jlut_val = lut[jlut_ptr];

  jump_ctrl #(.PC_W(PC_W), .ABS_JUMP(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_en(branch_en), .branch_cond(branch_cond), .halt_req(halt_req),
    .jptr_in(jptr_in), .jlut_ptr(jlut_ptr), .jlut_val(jlut_val),
    .pc(pc), .pc_valid(pc_valid), .jump_taken(jump_taken), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    pc;
    bit    pv;
    bit    jt;
    bit    dn;
    int    jp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp_v);
    n_checks++;
    if (got == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      $display("[%0t] %s: pc=%0d pc_valid=%0b jump_taken=%0b done=%0b jlut_ptr=%0d",
               $time, mon_e.tag, pc, pc_valid, jump_taken, done, jlut_ptr);
      chk({mon_e.tag, ".pc"},         int'(pc),         mon_e.pc);
      chk({mon_e.tag, ".pc_valid"},   int'(pc_valid),   int'(mon_e.pv));
      chk({mon_e.tag, ".jump_taken"}, int'(jump_taken), int'(mon_e.jt));
      chk({mon_e.tag, ".done"},       int'(done),       int'(mon_e.dn));
      chk({mon_e.tag, ".jlut_ptr"},   int'(jlut_ptr),   mon_e.jp);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input string tag, input bit st, input bit sl, input bit be, input bit bc,
                     input bit hr, input int jp, input int e_pc, input bit e_pv, input bit e_jt,
                     input bit e_dn, input int e_jp);
    exp_t e;
    start = st; stall = sl; branch_en = be; branch_cond = bc; halt_req = hr;
    jptr_in = jp[7:0];
    e.tag = tag; e.pc = e_pc; e.pv = e_pv; e.jt = e_jt; e.dn = e_dn; e.jp = e_jp;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".pc"},         int'(pc),         0);
    chk({tag, ".pc_valid"},   int'(pc_valid),   0);
    chk({tag, ".jump_taken"}, int'(jump_taken), 0);
    chk({tag, ".done"},       int'(done),       0);
    chk({tag, ".jlut_ptr"},   int'(jlut_ptr),   0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) lut[i] = 8'h00;
    lut[1] = 8'hFD;   // -3
    lut[2] = 8'h05;   // +5
    lut[4] = 8'hFC;   // -4
    lut[6] = 8'h00;   // jump to self

    repeat (2) @(posedge clk);
    #2;
    chk_reset_outputs("reset");
    reset = 1'b0;

    // start, then straight-line execution
    cyc("start",  1,0,0,0,0,0,  0,1,0,0,0);
    cyc("inc1",   0,0,0,0,0,0,  1,1,0,0,0);
    cyc("inc2",   0,0,0,0,0,0,  2,1,0,0,0);
    cyc("inc3",   0,0,0,0,0,0,  3,1,0,0,0);
    cyc("inc4",   0,0,0,0,0,0,  4,1,0,0,0);
    cyc("inc5",   0,0,0,0,0,0,  5,1,0,0,0);
    // taken branch at pc=5, offset -3 -> 2
    cyc("br5",    0,0,1,1,0,1,  5,0,0,0,1);
    cyc("land2",  0,0,0,0,0,0,  2,1,1,0,1);
    cyc("post2",  0,0,0,0,0,0,  3,1,0,0,1);
    cyc("inc4b",  0,0,0,0,0,0,  4,1,0,0,1);
    // stall with a taken branch pending, then the branch goes through
    cyc("stall1", 0,1,1,1,0,2,  4,1,0,0,1);
    cyc("stall2", 0,1,1,1,0,2,  4,1,0,0,1);
    cyc("stall3", 0,1,1,1,0,2,  4,1,0,0,1);
    cyc("br4",    0,0,1,1,0,2,  4,0,0,0,2);
    cyc("land9",  0,0,0,0,0,0,  9,1,1,0,2);
    // halt beats a taken branch; DONE ignores halt/branch/stall
    cyc("halt9",  0,0,1,1,1,3,  9,0,0,1,2);
    cyc("donehd", 0,1,1,1,1,3,  9,0,0,1,2);
    cyc("restart",1,0,0,0,0,0,  0,1,0,0,2);
    for (int i = 1; i <= 7; i++)
      cyc($sformatf("run%0d", i), 0,0,0,0,0,0, i,1,0,0,2);
    // untaken branch at pc=7, then start ignored in RUN
    cyc("nobr7",  0,0,1,0,0,5,  8,1,0,0,2);
    cyc("stRun",  1,0,0,0,0,0,  9,1,0,0,2);
    // restart and walk to pc=2 for the negative wrap
    cyc("halt",   0,0,0,0,1,0,  9,0,0,1,2);
    cyc("rst0",   1,0,0,0,0,0,  0,1,0,0,2);
    cyc("to1",    0,0,0,0,0,0,  1,1,0,0,2);
    cyc("to2",    0,0,0,0,0,0,  2,1,0,0,2);
    cyc("br2",    0,0,1,1,0,4,  2,0,0,0,4);
    cyc("wrapN",  0,0,0,0,0,0,  1022,1,1,0,4);
    cyc("br1022", 0,0,1,1,0,2,  1022,0,0,0,2);
    cyc("wrapP",  0,0,0,0,0,0,  3,1,1,0,2);
    // 3 - 4 -> 1023, then increment wraps to 0
    cyc("br3",    0,0,1,1,0,4,  3,0,0,0,4);
    cyc("land1023",0,0,0,0,0,0, 1023,1,1,0,4);
    cyc("incWrap",0,0,0,0,0,0,  0,1,0,0,4);
    // zero offset jumps to self
    cyc("brSelf", 0,0,1,1,0,6,  0,0,0,0,6);
    cyc("landSelf",0,0,0,0,0,0, 0,1,1,0,6);
    cyc("to1b",   0,0,0,0,0,0,  1,1,0,0,6);
    cyc("brRst",  0,0,1,1,0,2,  1,0,0,0,2);

    // async reset mid-JUMP: outputs clear before the next edge
    start = 0; stall = 0; branch_en = 0; branch_cond = 0; halt_req = 0;
    reset = 1'b1;
    #1;
    chk_reset_outputs("asyncRst");
    #1;
    reset = 1'b0;
    cyc("postRst1", 0,0,0,0,0,0, 0,0,0,0,0);
    cyc("postRst2", 0,0,0,0,0,0, 0,0,0,0,0);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
